// File: rtl/mpmc10_pipe_wb.sv
// Elastic register pipeline for flat Wishbone write-request payloads, with occupancy count.
// Latency: STAGES cycles on an empty pipe. Backpressure: SKID=1 gives a registered ready
// (two entries per stage); SKID=0 gives one entry per stage and a combinational ready chain.
module mpmc10_pipe_wb #(
    parameter int WID    = 200,
    parameter int STAGES = 1,
    parameter int SKID   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             i_valid,
    output logic                             i_ready,
    input  logic [WID-1:0]                   i_data,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic [WID-1:0]                   o_data,
    output logic [$clog2(2*STAGES+1)-1:0]    count
);

    localparam int CW = $clog2(2*STAGES+1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

    // Index g is the input side of stage g; index STAGES is the pipe output.
    logic           stg_vld [STAGES+1];
    logic           stg_rdy [STAGES+1];
    logic [WID-1:0] stg_dat [STAGES+1];

    assign stg_vld[0]      = i_valid;
    assign stg_dat[0]      = i_data;
    assign stg_rdy[STAGES] = o_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (SKID != 0) begin : g_skid
            stage_st_e      state_q, state_d;
            logic [WID-1:0] m_q, m_d;
            logic [WID-1:0] s_q, s_d;
            logic           in_v, out_r;

            always_comb begin
                state_d = state_q;
                m_d     = m_q;
                s_d     = s_q;
                in_v    = stg_vld[g] && (state_q != ST_FULL);
                out_r   = stg_rdy[g+1];
                case (state_q)
                    ST_EMPTY: begin
                        if (in_v) begin
                            state_d = ST_BUSY;
                            m_d     = stg_dat[g];
                        end
                    end
                    ST_BUSY: begin
                        if (in_v && out_r) begin
                            m_d = stg_dat[g];
                        end else if (in_v) begin
                            state_d = ST_FULL;
                            s_d     = stg_dat[g];
                        end else if (out_r) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (out_r) begin
                            state_d = ST_BUSY;
                            m_d     = s_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                if (clr) begin
                    state_d = ST_EMPTY;
                    m_d     = '0;
                    s_d     = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                    m_q     <= '0;
                    s_q     <= '0;
                end else begin
                    state_q <= state_d;
                    m_q     <= m_d;
                    s_q     <= s_d;
                end
            end

            // Ready depends only on the state flop, so o_ready never reaches i_ready.
            assign stg_rdy[g]   = (state_q != ST_FULL);
            assign stg_vld[g+1] = (state_q != ST_EMPTY);
            assign stg_dat[g+1] = m_q;
        end else begin : g_flow
            logic           vld_q, vld_d;
            logic [WID-1:0] m_q, m_d;
            logic           in_rdy, in_v, out_r;

            always_comb begin
                vld_d  = vld_q;
                m_d    = m_q;
                out_r  = stg_rdy[g+1];
                in_rdy = !vld_q || out_r;
                in_v   = stg_vld[g] && in_rdy;
                if (in_v) begin
                    vld_d = 1'b1;
                    m_d   = stg_dat[g];
                end else if (out_r) begin
                    vld_d = 1'b0;
                end
                if (clr) begin
                    vld_d = 1'b0;
                    m_d   = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    m_q   <= '0;
                end else begin
                    vld_q <= vld_d;
                    m_q   <= m_d;
                end
            end

            assign stg_rdy[g]   = in_rdy;
            assign stg_vld[g+1] = vld_q;
            assign stg_dat[g+1] = m_q;
        end
    end

    assign i_ready = !rst && stg_rdy[0];
    assign o_valid = stg_vld[STAGES];
    assign o_data  = stg_dat[STAGES];

    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_xfer, out_xfer;

    always_comb begin
        in_xfer  = i_valid && i_ready;
        out_xfer = o_valid && o_ready;
        cnt_d    = cnt_q;
        if (in_xfer && !out_xfer) begin
            cnt_d = cnt_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_mpmc10_pipe_wb.sv
// Bench for mpmc10_pipe_wb: four configurations (1/skid, 3/skid, 2/flow, 4/skid) driven
// sequentially; inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_mpmc10_pipe_wb;

    localparam int W = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic rst_a, clr_a, iv_a, ir_a, ov_a, or_a;
    logic [W-1:0] id_a, od_a;
    logic [1:0] cnt_a;
    logic rst_b, clr_b, iv_b, ir_b, ov_b, or_b;
    logic [W-1:0] id_b, od_b;
    logic [2:0] cnt_b;
    logic rst_c, clr_c, iv_c, ir_c, ov_c, or_c;
    logic [W-1:0] id_c, od_c;
    logic [2:0] cnt_c;
    logic rst_d, clr_d, iv_d, ir_d, ov_d, or_d;
    logic [W-1:0] id_d, od_d;
    logic [3:0] cnt_d;

    mpmc10_pipe_wb #(.WID(W), .STAGES(1), .SKID(1)) u_a (
        .clk(clk), .rst(rst_a), .clr(clr_a), .i_valid(iv_a), .i_ready(ir_a), .i_data(id_a),
        .o_valid(ov_a), .o_ready(or_a), .o_data(od_a), .count(cnt_a));
    mpmc10_pipe_wb #(.WID(W), .STAGES(3), .SKID(1)) u_b (
        .clk(clk), .rst(rst_b), .clr(clr_b), .i_valid(iv_b), .i_ready(ir_b), .i_data(id_b),
        .o_valid(ov_b), .o_ready(or_b), .o_data(od_b), .count(cnt_b));
    mpmc10_pipe_wb #(.WID(W), .STAGES(2), .SKID(0)) u_c (
        .clk(clk), .rst(rst_c), .clr(clr_c), .i_valid(iv_c), .i_ready(ir_c), .i_data(id_c),
        .o_valid(ov_c), .o_ready(or_c), .o_data(od_c), .count(cnt_c));
    mpmc10_pipe_wb #(.WID(W), .STAGES(4), .SKID(1)) u_d (
        .clk(clk), .rst(rst_d), .clr(clr_d), .i_valid(iv_d), .i_ready(ir_d), .i_data(id_d),
        .o_valid(ov_d), .o_ready(or_d), .o_data(od_d), .count(cnt_d));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {25{b}};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       iv;
        logic       ordy;
        logic [7:0] dat;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ec;
        logic       er;
    } vec_t;

    vec_t tv [13];
    logic [W-1:0] q [$];
    logic [W-1:0] exp_w, cur;
    int sent, got, lat;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        {rst_a, rst_b, rst_c, rst_d} = 4'hF;
        {clr_a, clr_b, clr_c, clr_d} = 4'h0;
        {iv_a, iv_b, iv_c, iv_d}     = 4'h0;
        {or_a, or_b, or_c, or_d}     = 4'hF;
        id_a = '0; id_b = '0; id_c = '0; id_d = '0;

        //          rst   clr   iv    ordy  dat    ev    ed     ec     er
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5, 2'd1, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A, 2'd1, 1'b1};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 8'h5A, 2'd2, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h5A, 2'd2, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hC3, 2'd1, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 2'd1, 1'b1};
        tv[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 2'd0, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};

        repeat (2) @(negedge clk);
        rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        // T1: single skid stage, table-driven
        for (int i = 0; i < 13; i++) begin
            rst_a = tv[i].rst; clr_a = tv[i].clr; iv_a = tv[i].iv;
            or_a  = tv[i].ordy; id_a = rep(tv[i].dat);
            @(negedge clk);
            chk($sformatf("t1_o_valid[%0d]", i), ov_a, tv[i].ev);
            chk($sformatf("t1_count[%0d]", i), cnt_a, tv[i].ec);
            chk($sformatf("t1_i_ready[%0d]", i), ir_a, tv[i].er);
            if (tv[i].ev) chk($sformatf("t1_o_data[%0d]", i), od_a, rep(tv[i].ed));
        end
        iv_a = 1'b0;

        // T2: 3 skid stages stalled, stream words 1..8
        or_b = 1'b0; sent = 1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            iv_b = (sent <= 8); id_b = rep(8'(sent));
            #1;
            if (iv_b && ir_b) begin
                q.push_back(rep(8'(sent)));
                sent++;
            end
            @(negedge clk);
        end
        chk("t2_accepted", q.size(), 6);
        chk("t2_i_ready", ir_b, 1'b0);
        chk("t2_count", cnt_b, 6);
        chk("t2_o_valid", ov_b, 1'b1);
        chk("t2_hold_data", od_b, rep(8'd1));
        iv_b = 1'b0; or_b = 1'b1;
        for (int cyc = 0; cyc < 30 && q.size() > 0; cyc++) begin
            if (ov_b) begin
                exp_w = q.pop_front();
                chk("t2_order", od_b, exp_w);
            end
            @(negedge clk);
        end
        chk("t2_drained", q.size(), 0);
        chk("t2_count_end", cnt_b, 0);

        // T3: 2 flow-through stages, random valid/ready, 1000 words
        q.delete(); sent = 0; got = 0; cur = rnd();
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            chk("t3_count", cnt_c, q.size());
            iv_c = (sent < 1000) && ($urandom_range(0, 3) != 0);
            id_c = cur;
            or_c = 1'($urandom_range(0, 1));
            #1;
            if (ov_c && or_c) begin
                if (q.size() == 0) begin
                    chk("t3_spurious", ov_c, 1'b0);
                end else begin
                    exp_w = q.pop_front();
                    chk("t3_data", od_c, exp_w);
                end
                got++;
            end
            if (iv_c && ir_c) begin
                q.push_back(cur);
                sent++;
                cur = rnd();
            end
            @(negedge clk);
        end
        iv_c = 1'b0;
        chk("t3_delivered", got, 1000);
        chk("t3_sent", sent, 1000);
        chk("t3_empty", q.size(), 0);

        // T4: 4 skid stages, continuous traffic
        or_d = 1'b1; iv_d = 1'b1; id_d = rep(8'h10);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk($sformatf("t4_o_valid[%0d]", n), ov_d, (n >= 4));
            if (n >= 4) chk($sformatf("t4_o_data[%0d]", n), od_d, rep(8'(8'h10 + n - 4)));
            chk($sformatf("t4_count[%0d]", n), cnt_d, (n < 4) ? n : 4);
            chk($sformatf("t4_i_ready[%0d]", n), ir_d, 1'b1);
            id_d = rep(8'(8'h10 + n));
        end
        iv_d = 1'b0;

        // T5: fill B, flush with clr
        or_b = 1'b0; iv_b = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            id_b = rep(8'(8'h40 + cyc));
            @(negedge clk);
        end
        chk("t5_full", cnt_b, 6);
        clr_b = 1'b1; id_b = rep(8'hEE);
        @(negedge clk);
        chk("t5_o_valid", ov_b, 1'b0);
        chk("t5_count", cnt_b, 0);
        chk("t5_i_ready", ir_b, 1'b1);
        clr_b = 1'b0; iv_b = 1'b0; or_b = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            chk("t5_no_stale", ov_b, 1'b0);
            @(negedge clk);
        end
        iv_b = 1'b1; id_b = rep(8'h77); lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            iv_b = 1'b0;
            if (ov_b) begin
                lat = n;
                break;
            end
        end
        chk("t5_latency", lat, 3);
        chk("t5_data", od_b, rep(8'h77));
        repeat (3) @(negedge clk);

        // T6: reset with 3 words held
        or_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv_b = 1'b1; id_b = rep(8'(8'h90 + k));
            @(negedge clk);
        end
        chk("t6_loaded", cnt_b, 3);
        rst_b = 1'b1; iv_b = 1'b1;
        @(negedge clk);
        chk("t6_rst_o_valid", ov_b, 1'b0);
        chk("t6_rst_count", cnt_b, 0);
        chk("t6_rst_i_ready", ir_b, 1'b0);
        @(negedge clk);
        chk("t6_rst_i_ready2", ir_b, 1'b0);
        rst_b = 1'b0; iv_b = 1'b0; or_b = 1'b1;
        @(negedge clk);
        chk("t6_post_i_ready", ir_b, 1'b1);
        chk("t6_post_count", cnt_b, 0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            chk("t6_no_stale", ov_b, 1'b0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
